// File: rtl/store_unit_pkg.sv
// Shared encodings and the store-buffer entry layout for the MIPS
// data-memory write path. The load-side extender can reuse the size codes.
package store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } st_size_e;

  localparam int ENTRY_ADDR_W = 32;

  // One buffered word write: aligned address, lane-replicated data, lane enables
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              be;
  } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational narrowing/lane alignment of SB/SH/SW data into a 32-bit
// word write with byte enables, plus the alignment legality check.
module store_align
  import store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misal_o
);

  // Replicate the narrow datum across all lanes; the enables pick the lane(s)
  always_comb begin
    wdata_o = '0;
    be_o    = '0;
    misal_o = 1'b0;
    case (st_size_e'(size_i))
      SZ_BYTE: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        wdata_o = {2{data_i[15:0]}};
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misal_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        wdata_o = data_i;
        be_o    = 4'b1111;
        misal_o = |addr_lo_i;
      end
      default: begin
        misal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store buffer between the MEM stage and the data-memory port. Accepted
// legal stores are aligned and queued; rejected ones raise a one-cycle
// misalign pulse and record the faulting address.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              misalign,
  output logic [ADDR_W-1:0] bad_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t      buf_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

  logic [31:0]       al_wdata;
  logic [3:0]        al_be;
  logic              al_misal;
  logic              accept, push, pop, reject;
  store_entry_t      new_entry;
  store_entry_t      head;

  store_align u_align (
    .size_i    (st_size),
    .addr_lo_i (st_addr[1:0]),
    .data_i    (st_data),
    .wdata_o   (al_wdata),
    .be_o      (al_be),
    .misal_o   (al_misal)
  );

  assign st_ready = (count_q < CW'(DEPTH));
  assign mem_req  = (count_q != '0);
  assign busy     = mem_req;
  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;

  assign accept = st_valid && st_ready;
  assign push   = accept && !al_misal;
  assign reject = accept && al_misal;
  assign pop    = mem_req && mem_ack;

  assign new_entry.addr  = ENTRY_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00});
  assign new_entry.wdata = al_wdata;
  assign new_entry.be    = al_be;

  // Head entry is presented only while something is queued, so an empty
  // buffer drives zeros instead of stale slot contents
  assign head      = buf_q[rptr_q];
  assign mem_addr  = mem_req ? ADDR_W'(head.addr) : '0;
  assign mem_wdata = mem_req ? head.wdata : '0;
  assign mem_be    = mem_req ? head.be : '0;

  // Next-state for pointers, occupancy and the exception registers
  always_comb begin
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    misalign_d = reject;
    bad_addr_d = reject ? st_addr : bad_addr_q;
  end

  // Control state: reset drops every queued entry immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // Entry storage: written at the tail on a legal accept, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wptr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_store_unit;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_data = '0;
  logic [1:0]        st_size = '0;
  logic              misalign;
  logic [ADDR_W-1:0] bad_addr;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              busy;

  always #5 clk = ~clk;

  store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .misalign  (misalign),
    .bad_addr  (bad_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t        mq[$];
  logic        m_mis = 1'b0;
  logic [31:0] m_bad = '0;
  bit          m_acc;
  bit          m_pop;
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit is_bad(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz);
    ent_t e;
    logic [1:0] off;
    off     = a[1:0];
    e.addr  = a & ~32'h3;
    e.wdata = d;
    e.be    = 4'hF;
    if (sz == 2'd0) begin
      e.wdata = {24'b0, d[7:0]} * 32'h0101_0101;
      e.be    = 4'(1 << off);
    end else if (sz == 2'd1) begin
      e.wdata = {16'b0, d[15:0]} * 32'h0001_0001;
      e.be    = 4'(3 << off);
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: FIFO of aligned writes, updated at each clock edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_mis = 1'b0;
      m_bad = '0;
    end else begin
      m_acc = st_valid && (mq.size() < DEPTH);
      m_pop = mem_ack && (mq.size() != 0);
      m_mis = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        if (is_bad(st_size, st_addr[1:0])) begin
          m_mis = 1'b1;
          m_bad = st_addr;
        end else begin
          mq.push_back(mk(st_addr, st_data, st_size));
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
      check("mem_req",  32'(mem_req),  32'(mq.size() != 0));
      check("busy",     32'(busy),     32'(mq.size() != 0));
      check("misalign", 32'(misalign), 32'(m_mis));
      check("bad_addr", bad_addr,      m_bad);
      if (mq.size() != 0) begin
        check("mem_addr",  mem_addr,      mq[0].addr);
        check("mem_wdata", mem_wdata,     mq[0].wdata);
        check("mem_be",    32'(mem_be),   32'(mq[0].be));
      end else begin
        check("mem_addr_idle",  mem_addr,    32'h0);
        check("mem_wdata_idle", mem_wdata,   32'h0);
        check("mem_be_idle",    32'(mem_be), 32'h0);
      end
    end
  end

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int ack_mode;

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    check("rst_ready",    32'(st_ready), 32'h1);
    check("rst_mem_req",  32'(mem_req),  32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_mis",      32'(misalign), 32'h0);
    check("rst_bad",      bad_addr,      32'h0);
    check("rst_mem_addr", mem_addr,      32'h0);

    // SB to the top byte lane with ack tied high
    mem_ack = 1'b1;
    st_valid = 1'b1; st_addr = 32'h1003; st_data = 32'h0000_00AB; st_size = 2'd0;
    step();
    st_valid = 1'b0;
    check("sb_req",   32'(mem_req),  32'h1);
    check("sb_addr",  mem_addr,      32'h1000);
    check("sb_wdata", mem_wdata,     32'hABAB_ABAB);
    check("sb_be",    32'(mem_be),   32'h8);
    step();
    check("sb_idle",  32'(busy),     32'h0);

    // SH to the upper half, held until ack
    mem_ack = 1'b0;
    st_valid = 1'b1; st_addr = 32'h2002; st_data = 32'hFFFF_1234; st_size = 2'd1;
    step();
    st_valid = 1'b0;
    check("sh_be",    32'(mem_be),   32'hC);
    check("sh_wdata", mem_wdata,     32'h1234_1234);
    step();
    check("sh_held",  mem_wdata,     32'h1234_1234);
    mem_ack = 1'b1;
    step();
    check("sh_idle",  32'(busy),     32'h0);

    // Misaligned SW
    st_valid = 1'b1; st_addr = 32'h2002; st_data = 32'hDEAD_BEEF; st_size = 2'd2;
    step();
    st_valid = 1'b0;
    check("sw_mis",   32'(misalign), 32'h1);
    check("sw_bad",   bad_addr,      32'h2002);
    check("sw_noreq", 32'(mem_req),  32'h0);
    step();
    check("sw_pulse", 32'(misalign), 32'h0);

    // Illegal size, two in a row
    st_valid = 1'b1; st_addr = 32'h40; st_size = 2'd3;
    step();
    check("ill_mis0", 32'(misalign), 32'h1);
    check("ill_bad0", bad_addr,      32'h40);
    st_addr = 32'h44;
    step();
    st_valid = 1'b0;
    check("ill_mis1", 32'(misalign), 32'h1);
    check("ill_bad1", bad_addr,      32'h44);
    step();
    check("ill_end",  32'(misalign), 32'h0);

    // Fill with ack held low, third SW stalls, then drain
    mem_ack = 1'b0;
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h100; st_data = 32'h1111_1111;
    step();
    st_addr = 32'h104; st_data = 32'h2222_2222;
    step();
    check("full_ready", 32'(st_ready), 32'h0);
    st_addr = 32'h108; st_data = 32'h3333_3333;
    step();
    check("stall_ready", 32'(st_ready), 32'h0);
    check("stall_head",  mem_addr,      32'h100);
    mem_ack = 1'b1;
    step();
    check("drain0_addr", mem_addr,      32'h104);
    check("drain0_rdy",  32'(st_ready), 32'h1);
    step();
    st_valid = 1'b0;
    check("both_addr",   mem_addr,      32'h108);
    check("both_data",   mem_wdata,     32'h3333_3333);
    check("both_req",    32'(mem_req),  32'h1);
    step();
    check("drain_idle",  32'(busy),     32'h0);

    // Reset while two entries are pending
    mem_ack = 1'b0;
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h300;
    step();
    st_addr = 32'h304;
    step();
    st_valid = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'h1);
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    check("rst_req_drop", 32'(mem_req),  32'h0);
    check("rst_busy_drop", 32'(busy),    32'h0);
    step();
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("post_rst_rdy",  32'(st_ready), 32'h1);
    check("post_rst_busy", 32'(busy),     32'h0);
    step();

    // Randomized traffic
    ack_mode = 0;
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) ack_mode = $urandom_range(0, 2);
      case (ack_mode)
        0:       mem_ack = ($urandom_range(0, 1) == 1);
        1:       mem_ack = 1'b1;
        default: mem_ack = ($urandom_range(0, 7) == 0);
      endcase
      st_valid = ($urandom_range(0, 9) < 6);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      st_size = sz;
      st_addr = a;
      st_data = $urandom;
      step();
    end
    st_valid = 1'b0;
    mem_ack = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
